fft6_cmplx_combine: RTL and testbench

- Downstream consumer of the four sign-magnitude real multipliers in the FFT-6 twiddle stage.
- Collects products rr=ar*br, ii=ai*bi, ri=ar*bi, ir=ai*br, each with its own ready strobe, in any order.
- Converts each to two's complement and forms the complex product: re = rr - ii, im = ri + ir.
- Presents registered results to the butterfly adder with a one-cycle valid pulse; a watchdog aborts an operation when a product never arrives.

---
 rtl/fft6_pkg.sv | 18 +
 rtl/fft6_cmplx_combine_if.sv | 29 ++
 rtl/fft6_sm_to_tc.sv | 14 +
 rtl/fft6_cmplx_combine.sv | 128 ++++++++++++
 tb/tb_fft6_cmplx_combine.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft6_pkg.sv
// Shared widths, channel indices and state encoding for the FFT-6 complex product combiner.
package fft6_pkg;
    localparam int PROD_W = 17;
    localparam int MAG_W  = 16;
    localparam int OUT_W  = 18;
    localparam int NUM_CH = 4;

    localparam int RR = 0;
    localparam int II = 1;
    localparam int RI = 2;
    localparam int IR = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;
endpackage

// File: rtl/fft6_cmplx_combine_if.sv
// Product inputs from the four real multipliers and the result bus toward the butterfly adder.
interface fft6_cmplx_combine_if
    import fft6_pkg::*;
();
    logic                     start;
    logic [PROD_W-1:0]        p_rr;
    logic [PROD_W-1:0]        p_ii;
    logic [PROD_W-1:0]        p_ri;
    logic [PROD_W-1:0]        p_ir;
    logic                     rdy_rr;
    logic                     rdy_ii;
    logic                     rdy_ri;
    logic                     rdy_ir;
    logic signed [OUT_W-1:0]  out_re;
    logic signed [OUT_W-1:0]  out_im;
    logic                     out_valid;
    logic                     busy;
    logic                     timeout;

    modport master (
        output start, p_rr, p_ii, p_ri, p_ir, rdy_rr, rdy_ii, rdy_ri, rdy_ir,
        input  out_re, out_im, out_valid, busy, timeout
    );

    modport slave (
        input  start, p_rr, p_ii, p_ri, p_ir, rdy_rr, rdy_ii, rdy_ri, rdy_ir,
        output out_re, out_im, out_valid, busy, timeout
    );
endinterface

// File: rtl/fft6_sm_to_tc.sv
// Sign-magnitude product to sign-extended two's complement; a negative zero yields 0.
module fft6_sm_to_tc
    import fft6_pkg::*;
#(
    parameter logic NEG_FLAG = 1'b0
) (
    input  logic [PROD_W-1:0]       prod,
    output logic signed [OUT_W-1:0] value
);
    logic [OUT_W-1:0] mag_ext;

    assign mag_ext = OUT_W'(prod[MAG_W-1:0]);
    assign value   = (prod[PROD_W-1] == NEG_FLAG) ? -$signed(mag_ext) : $signed(mag_ext);
endmodule

// File: rtl/fft6_cmplx_combine.sv
// Collects the four real partial products in any order and emits re = rr - ii, im = ri + ir,
// with a watchdog that abandons a collection whose products never all arrive.
module fft6_cmplx_combine
    import fft6_pkg::*;
#(
    parameter logic NEG_FLAG = 1'b0,
    parameter int   TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft6_cmplx_combine_if.slave  bus
);
    localparam int              WD_W    = 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t                   state_reg, state_next;
    logic [WD_W-1:0]          wd_reg, wd_next;
    logic [NUM_CH-1:0]        flag_reg, flag_next;
    logic [NUM_CH-1:0]        rdy_vec, capture_en;
    logic [PROD_W-1:0]        prod_in  [NUM_CH];
    logic [PROD_W-1:0]        prod_reg [NUM_CH];
    logic signed [OUT_W-1:0]  tc_val   [NUM_CH];
    logic signed [OUT_W-1:0]  out_re_reg, out_im_reg, re_next, im_next;
    logic                     load_out, timeout_now, collecting;

    assign prod_in[RR] = bus.p_rr;
    assign prod_in[II] = bus.p_ii;
    assign prod_in[RI] = bus.p_ri;
    assign prod_in[IR] = bus.p_ir;
    assign rdy_vec     = {bus.rdy_ir, bus.rdy_ri, bus.rdy_ii, bus.rdy_rr};

    // Capture is suppressed by a restart and once the set is complete (waiting to emit).
    assign collecting = (state_reg == COLLECT) && !bus.start && !(&flag_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign capture_en[gi] = collecting && rdy_vec[gi] && !flag_reg[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prod_reg[gi] <= '0;
                end else if (capture_en[gi]) begin
                    prod_reg[gi] <= prod_in[gi];
                end
            end

            fft6_sm_to_tc #(.NEG_FLAG(NEG_FLAG)) u_cvt (
                .prod  (prod_reg[gi]),
                .value (tc_val[gi])
            );
        end
    endgenerate

    assign re_next = tc_val[RR] - tc_val[II];
    assign im_next = tc_val[RI] + tc_val[IR];

    always_comb begin
        state_next  = state_reg;
        wd_next     = wd_reg;
        flag_next   = flag_reg;
        load_out    = 1'b0;
        timeout_now = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = COLLECT;
                    flag_next  = '0;
                    wd_next    = '0;
                end
            end
            COLLECT: begin
                if (bus.start) begin
                    flag_next = '0;
                    wd_next   = '0;
                end else if (&flag_reg) begin
                    state_next = EMIT;
                    load_out   = 1'b1;
                end else begin
                    flag_next = flag_reg | capture_en;
                    // A set completed on the expiry edge still counts as completion.
                    if (wd_reg >= WD_LAST && !(&flag_next)) begin
                        timeout_now = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        wd_next = wd_reg + WD_W'(1);
                    end
                end
            end
            EMIT: begin
                if (bus.start) begin
                    state_next = COLLECT;
                    flag_next  = '0;
                    wd_next    = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wd_reg     <= '0;
            flag_reg   <= '0;
            out_re_reg <= '0;
            out_im_reg <= '0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
            flag_reg  <= flag_next;
            if (load_out) begin
                out_re_reg <= re_next;
                out_im_reg <= im_next;
            end
        end
    end

    assign bus.out_re    = out_re_reg;
    assign bus.out_im    = out_im_reg;
    assign bus.out_valid = (state_reg == EMIT);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.timeout   = timeout_now;
endmodule

// File: tb/tb_fft6_cmplx_combine.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_fft6_cmplx_combine;
    import fft6_pkg::*;

    localparam int TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fft6_cmplx_combine_if bus ();

    fft6_cmplx_combine #(.NEG_FLAG(1'b0), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int re;
        int im;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   last_re = 0;
    int   last_im = 0;

    logic [16:0] op_p    [4];
    int          op_off  [4];
    bit          op_drop [4];
    int          dup_ch  = -1;
    int          dup_off = 0;
    logic [16:0] dup_val = '0;

    // Sign flag 1 means non-negative, 0 means negative.
    function automatic int sm_val(input logic [16:0] p);
        int m;
        m = int'(p[15:0]);
        return p[16] ? m : -m;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic clr_rdy();
        bus.rdy_rr = 1'b0;
        bus.rdy_ii = 1'b0;
        bus.rdy_ri = 1'b0;
        bus.rdy_ir = 1'b0;
        bus.p_rr   = 17'($urandom);
        bus.p_ii   = 17'($urandom);
        bus.p_ri   = 17'($urandom);
        bus.p_ir   = 17'($urandom);
    endtask

    task automatic set_ch(input int ch, input logic [16:0] v);
        case (ch)
            RR:      begin bus.rdy_rr = 1'b1; bus.p_rr = v; end
            II:      begin bus.rdy_ii = 1'b1; bus.p_ii = v; end
            RI:      begin bus.rdy_ri = 1'b1; bus.p_ri = v; end
            default: begin bus.rdy_ir = 1'b1; bus.p_ir = v; end
        endcase
    endtask

    task automatic run_op(input string name);
        int s, last, endc, re, im;
        bit drop;
        @(posedge clk);
        #1;
        clr_rdy();
        bus.start = 1'b1;
        s    = cyc;
        last = 0;
        drop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (op_drop[i]) drop = 1'b1;
            else if (op_off[i] > last) last = op_off[i];
        end
        re = sm_val(op_p[RR]) - sm_val(op_p[II]);
        im = sm_val(op_p[RI]) + sm_val(op_p[IR]);
        if (drop) begin
            endc = s + TO;
            sb.push_back('{1'b1, last_re, last_im, endc});
        end else begin
            endc = s + last + 2;
            sb.push_back('{1'b0, re, im, endc});
            last_re = re;
            last_im = im;
        end
        $display("[TB] %s: start at cycle %0d, expect %s at cycle %0d re=%0d im=%0d",
                 name, s, drop ? "timeout" : "valid", endc, drop ? last_re : re, drop ? last_im : im);
        for (int c = s + 1; c <= endc + 1; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            clr_rdy();
            for (int i = 0; i < 4; i++)
                if (!op_drop[i] && op_off[i] == c - s) set_ch(i, op_p[i]);
            if (dup_ch >= 0 && dup_off == c - s) set_ch(dup_ch, dup_val);
            @(negedge clk);
            chk({name, "_busy"}, int'(bus.busy), (c <= endc) ? 1 : 0);
        end
        dup_ch = -1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.timeout === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: out_valid=%0b timeout=%0b, expected no event (cycle %0d)",
                             bus.out_valid, bus.timeout, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("out_valid", int'(bus.out_valid), e.is_to ? 0 : 1);
                    chk("timeout", int'(bus.timeout), e.is_to ? 1 : 0);
                    chk("out_re", int'(bus.out_re), e.re);
                    chk("out_im", int'(bus.out_im), e.im);
                    $display("[TB] event cycle %0d valid=%0b timeout=%0b re=%0d im=%0d",
                             cyc, bus.out_valid, bus.timeout, bus.out_re, bus.out_im);
                end
            end
        end
    end

    initial begin : stim
        bus.start = 1'b0;
        clr_rdy();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_re", int'(bus.out_re), 0);
        chk("rst_out_im", int'(bus.out_im), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four products in the same cycle.
        op_p    = '{{1'b1, 16'd100}, {1'b1, 16'd30}, {1'b0, 16'd20}, {1'b1, 16'd5}};
        op_off  = '{1, 1, 1, 1};
        op_drop = '{0, 0, 0, 0};
        run_op("t1_same_cycle");

        // Staggered arrival: ir, rr, ii, ri.
        op_off = '{7, 10, 12, 3};
        run_op("t2_staggered");

        // Magnitude extremes.
        op_p   = '{{1'b1, 16'd65025}, {1'b0, 16'd65025}, {1'b0, 16'd65025}, {1'b0, 16'd65025}};
        op_off = '{2, 1, 4, 3};
        run_op("t3_extremes");

        // Negative zero plus a duplicate rr strobe that must be ignored.
        op_p    = '{{1'b0, 16'd0}, {1'b1, 16'd1}, {1'b1, 16'd2}, {1'b1, 16'd3}};
        op_off  = '{1, 3, 4, 5};
        dup_ch  = RR;
        dup_off = 2;
        dup_val = {1'b1, 16'd500};
        run_op("t4_negzero_dup");

        // Withheld ii triggers the watchdog; a late ii strobe in IDLE does nothing.
        op_off  = '{1, 2, 3, 4};
        op_drop = '{0, 1, 0, 0};
        run_op("t5_timeout");
        op_drop = '{0, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            clr_rdy();
            set_ch(II, {1'b1, 16'd7});
            @(negedge clk);
            chk("t5_late_busy", int'(bus.busy), 0);
            chk("t5_hold_re", int'(bus.out_re), last_re);
            chk("t5_hold_im", int'(bus.out_im), last_im);
        end

        // Reset in the middle of a collection.
        @(posedge clk);
        #1;
        clr_rdy();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        set_ch(RR, {1'b1, 16'd999});
        set_ch(II, {1'b0, 16'd888});
        @(posedge clk);
        #1;
        clr_rdy();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        last_re = 0;
        last_im = 0;
        chk("t6_rst_out_re", int'(bus.out_re), 0);
        chk("t6_rst_out_im", int'(bus.out_im), 0);
        chk("t6_rst_out_valid", int'(bus.out_valid), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_timeout", int'(bus.timeout), 0);
        op_p   = '{{1'b1, 16'd11}, {1'b1, 16'd4}, {1'b0, 16'd9}, {1'b1, 16'd2}};
        op_off = '{2, 1, 3, 1};
        run_op("t6_after_reset");

        // Restart mid-collection after a full set of junk products has been captured.
        @(posedge clk);
        #1;
        clr_rdy();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, {1'b0, 16'd4321});
        op_p   = '{{1'b0, 16'd250}, {1'b1, 16'd50}, {1'b1, 16'd600}, {1'b0, 16'd7}};
        op_off = '{1, 2, 2, 1};
        run_op("t6_restart");

        // Randomized operations, some with a withheld product.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_p[i]    = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 65025))};
                op_off[i]  = $urandom_range(1, 15);
                op_drop[i] = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) op_drop[$urandom_range(0, 3)] = 1'b1;
            run_op($sformatf("rand%0d", n));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
